spu_fetch_issue: RTL and testbench

- Instruction fetch and dual-issue unit that drives the SPU execution core.
- Holds a 64-entry buffer of predecoded instructions and fetches a pair each cycle.
- Steers each instruction to its even or odd lane and drives the core's program_counter, opcode, register and immediate inputs.
- Consumes the core's branch_taken, branch_value and stop outputs to redirect or halt.

---
 rtl/spu_fetch_pkg.sv | 36 +++
 rtl/spu_issue_check.sv | 27 ++
 rtl/spu_fetch_issue.sv | 134 +++++++++++++
 tb/tb_spu_fetch_issue.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/spu_fetch_pkg.sv
// Shared types and constants for the SPU fetch/issue unit.
// Record layout mirrors the predecoded load_data word, MSB first.
package spu_fetch_pkg;

  localparam int DEPTH = 64;
  localparam int PC_W  = 6;

  localparam logic [10:0] EVEN_NOP = 11'h201;
  localparam logic [10:0] ODD_NOP  = 11'h001;

  localparam logic LANE_EVEN = 1'b1;
  localparam logic LANE_ODD  = 1'b0;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, HALT} fetch_state_t;

  typedef struct packed {
    logic [10:0] opcode;
    logic [6:0]  rt;
    logic [6:0]  ra;
    logic [6:0]  rb;
    logic [6:0]  rc;
    logic [17:0] imm;
    logic        write_back;
    logic [3:0]  forward_stage;
    logic        pipe;
  } instr_rec_t;

  function automatic instr_rec_t nop_rec(input logic lane);
    instr_rec_t r;
    r        = '0;
    r.opcode = lane ? EVEN_NOP : ODD_NOP;
    r.pipe   = lane;
    return r;
  endfunction

endpackage

// File: rtl/spu_issue_check.sv
// Pair-issue decision: decides whether A and B can go out together and
// steers each record onto the lane named by its pipe bit.
module spu_issue_check
  import spu_fetch_pkg::*;
(
  input  instr_rec_t       a_i,
  input  instr_rec_t       b_i,
  input  logic [PC_W-1:0]  pc_i,
  output logic             dual_ok_o,
  output instr_rec_t [1:0] lane_o
);

  logic raw_hazard;

  always_comb begin
    raw_hazard = a_i.write_back &&
                 ((a_i.rt == b_i.ra) || (a_i.rt == b_i.rb) || (a_i.rt == b_i.rc));
    // B at PC 63 would be entry 0, which is not a sequential successor.
    dual_ok_o  = (pc_i != PC_W'(DEPTH - 1)) && (a_i.pipe != b_i.pipe) && !raw_hazard;

    lane_o[LANE_EVEN] = nop_rec(LANE_EVEN);
    lane_o[LANE_ODD]  = nop_rec(LANE_ODD);
    lane_o[a_i.pipe]  = a_i;
    if (dual_ok_o) lane_o[b_i.pipe] = b_i;
  end

endmodule

// File: rtl/spu_fetch_issue.sv
// Instruction buffer, fetch FSM and registered issue outputs for the SPU core.
// state | meaning
// IDLE  | buffer loadable, NOPs out, waits for start
// RUN   | fetch/issue one or two instructions per cycle
// FLUSH | one NOP cycle after a redirect, then resume at new PC
// HALT  | frozen with NOPs until reset
module spu_fetch_issue
  import spu_fetch_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              load_en,
  input  logic [5:0]        load_addr,
  input  logic [62:0]       load_data,
  input  logic              branch_taken,
  input  logic signed [15:0] branch_value,
  input  logic              stop,
  output logic [5:0]        program_counter,
  output logic [1:0][10:0]  opcode,
  output logic [1:0][6:0]   ra,
  output logic [1:0][6:0]   rb,
  output logic [1:0][6:0]   rc,
  output logic [1:0][6:0]   rt,
  output logic [1:0][17:0]  immediate,
  output logic [1:0]        write_back,
  output logic [1:0][3:0]   forward_stage,
  output logic              dual_issued,
  output logic              halted
);

  fetch_state_t     state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [PC_W-1:0]  pc_out_q, pc_out_d;
  instr_rec_t [1:0] lane_q, lane_d;
  logic             dual_q, dual_d;
  logic             halted_q, halted_d;

  instr_rec_t       mem_q [DEPTH];
  instr_rec_t       rec_a, rec_b;
  instr_rec_t [1:0] issue_lane;
  logic             dual_ok;
  logic [PC_W-1:0]  pc_plus1;
  logic             unused_bits;

  assign pc_plus1 = pc_q + PC_W'(1);
  assign rec_a    = mem_q[pc_q];
  assign rec_b    = mem_q[pc_plus1];

  spu_issue_check u_check (
    .a_i       (rec_a),
    .b_i       (rec_b),
    .pc_i      (pc_q),
    .dual_ok_o (dual_ok),
    .lane_o    (issue_lane)
  );

  always_ff @(posedge clock) begin
    if (!reset && state_q == IDLE && load_en) mem_q[load_addr] <= load_data;
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pc_out_d = pc_out_q;
    lane_d   = {nop_rec(LANE_EVEN), nop_rec(LANE_ODD)};
    dual_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          pc_d    = '0;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = HALT;
        end else if (branch_taken) begin
          state_d = FLUSH;
          pc_d    = branch_value[PC_W-1:0];
        end else begin
          lane_d   = issue_lane;
          pc_out_d = pc_q;
          dual_d   = dual_ok;
          pc_d     = dual_ok ? pc_q + PC_W'(2) : pc_plus1;
        end
      end
      FLUSH: begin
        if (stop)              state_d = HALT;
        else if (branch_taken) pc_d = branch_value[PC_W-1:0];
        else                   state_d = RUN;
      end
      HALT: ;
      default: state_d = IDLE;
    endcase
    halted_d = (state_d == HALT);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      pc_out_q <= '0;
      lane_q   <= {nop_rec(LANE_EVEN), nop_rec(LANE_ODD)};
      dual_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pc_out_q <= pc_out_d;
      lane_q   <= lane_d;
      dual_q   <= dual_d;
      halted_q <= halted_d;
    end
  end

  for (genvar l = 0; l < 2; l++) begin : g_lane
    assign opcode[l]        = lane_q[l].opcode;
    assign rt[l]            = lane_q[l].rt;
    assign ra[l]            = lane_q[l].ra;
    assign rb[l]            = lane_q[l].rb;
    assign rc[l]            = lane_q[l].rc;
    assign immediate[l]     = lane_q[l].imm;
    assign write_back[l]    = lane_q[l].write_back;
    assign forward_stage[l] = lane_q[l].forward_stage;
  end

  assign program_counter = pc_out_q;
  assign dual_issued     = dual_q;
  assign halted          = halted_q;

  assign unused_bits = ^{branch_value[15:PC_W], lane_q[1].pipe, lane_q[0].pipe};

endmodule

// File: tb/tb_spu_fetch_issue.sv
// Directed bench for spu_fetch_issue: loads a small program and walks the
// fetch/issue, redirect, halt and reset scenarios with hand-computed results.
module tb_spu_fetch_issue;

  logic              clock = 1'b0;
  logic              reset, start, load_en, branch_taken, stop;
  logic [5:0]        load_addr;
  logic [62:0]       load_data;
  logic signed [15:0] branch_value;
  logic [5:0]        program_counter;
  logic [1:0][10:0]  opcode;
  logic [1:0][6:0]   ra, rb, rc, rt;
  logic [1:0][17:0]  immediate;
  logic [1:0]        write_back;
  logic [1:0][3:0]   forward_stage;
  logic              dual_issued, halted;

  int checks = 0;
  int errors = 0;

  localparam logic [10:0] ENOP = 11'h201, ONOP = 11'h001;
  localparam logic [10:0] ADD = 11'h0C0, ROT = 11'h3AC, E2 = 11'h0C2, O3 = 11'h3A3;
  localparam logic [10:0] E4 = 11'h0C4, E5 = 11'h0C5, E6 = 11'h0C6;
  localparam logic [10:0] E16 = 11'h110, O17 = 11'h311, O62 = 11'h362, O63 = 11'h363;
  localparam logic [10:0] GARB = 11'h7FF;

  spu_fetch_issue dut (
    .clock(clock), .reset(reset), .start(start), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data), .branch_taken(branch_taken),
    .branch_value(branch_value), .stop(stop), .program_counter(program_counter),
    .opcode(opcode), .ra(ra), .rb(rb), .rc(rc), .rt(rt), .immediate(immediate),
    .write_back(write_back), .forward_stage(forward_stage),
    .dual_issued(dual_issued), .halted(halted)
  );

  always #5 clock = ~clock;

  function automatic logic [62:0] mk(input logic [10:0] opc, input logic [6:0] r_t,
                                     input logic [6:0] r_a, input logic [6:0] r_b,
                                     input logic [6:0] r_c, input logic [17:0] imm,
                                     input logic wb, input logic [3:0] fs, input logic pipe);
    return {opc, r_t, r_a, r_b, r_c, imm, wb, fs, pipe};
  endfunction

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic load_word(input logic [5:0] addr, input logic [62:0] data);
    load_en = 1'b1; load_addr = addr; load_data = data;
    tick();
    load_en = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 0; load_en = 0; load_addr = 0; load_data = 0;
    branch_taken = 0; branch_value = 0; stop = 0;
    tick(); tick();
    reset = 1'b0;
    checks++; if (opcode !== {ENOP, ONOP}) begin errors++; $display("FAIL reset_opcode got %h want %h", opcode, {ENOP, ONOP}); end
    checks++; if (write_back !== 2'b00) begin errors++; $display("FAIL reset_wb got %b want 00", write_back); end
    checks++; if (halted !== 1'b0 || dual_issued !== 1'b0) begin errors++; $display("FAIL reset_flags got halted=%b dual=%b want 0 0", halted, dual_issued); end
    checks++; if (program_counter !== 6'd0) begin errors++; $display("FAIL reset_pc got %0d want 0", program_counter); end
  endtask

  task automatic load_program;
    load_word(6'd0,  mk(ADD, 7'd5,  7'd1, 7'd2, 7'd0, 18'h00010, 1'b1, 4'h2, 1'b1));
    load_word(6'd1,  mk(ROT, 7'd6,  7'd7, 7'd8, 7'd0, 18'h3FFFF, 1'b1, 4'h4, 1'b0));
    load_word(6'd2,  mk(E2,  7'd9,  7'd1, 7'd1, 7'd1, 18'h0,     1'b1, 4'h0, 1'b1));
    load_word(6'd3,  mk(O3,  7'd11, 7'd9, 7'd0, 7'd0, 18'h0,     1'b1, 4'h0, 1'b0));
    load_word(6'd4,  mk(E4,  7'd12, 7'd11,7'd0, 7'd0, 18'h0,     1'b0, 4'h0, 1'b1));
    load_word(6'd5,  mk(E5,  7'd13, 7'd0, 7'd0, 7'd0, 18'h0,     1'b0, 4'h0, 1'b1));
    load_word(6'd6,  mk(E6,  7'd14, 7'd0, 7'd0, 7'd0, 18'h0,     1'b0, 4'h0, 1'b1));
    load_word(6'd16, mk(E16, 7'd20, 7'd0, 7'd0, 7'd0, 18'h0,     1'b0, 4'h0, 1'b1));
    load_word(6'd17, mk(O17, 7'd21, 7'd22,7'd23,7'd24,18'h00123, 1'b1, 4'h1, 1'b0));
    load_word(6'd62, mk(O62, 7'd30, 7'd0, 7'd0, 7'd0, 18'h0,     1'b0, 4'h0, 1'b0));
    load_word(6'd63, mk(O63, 7'd31, 7'd0, 7'd0, 7'd0, 18'h0,     1'b0, 4'h0, 1'b0));
    checks++; if (opcode !== {ENOP, ONOP} || dual_issued !== 1'b0) begin errors++; $display("FAIL idle_nop got %h want %h", opcode, {ENOP, ONOP}); end
  endtask

  task automatic test_dual_issue;
    start = 1'b1; tick(); start = 1'b0;
    tick();
    checks++; if (dual_issued !== 1'b1) begin errors++; $display("FAIL dual0_flag got %b want 1", dual_issued); end
    checks++; if (opcode !== {ADD, ROT}) begin errors++; $display("FAIL dual0_opcode got %h want %h", opcode, {ADD, ROT}); end
    checks++; if (program_counter !== 6'd0) begin errors++; $display("FAIL dual0_pc got %0d want 0", program_counter); end
    checks++; if (immediate !== {18'h00010, 18'h3FFFF} || write_back !== 2'b11) begin errors++; $display("FAIL dual0_imm_wb got %h/%b want 000103ffff/11", immediate, write_back); end
    checks++; if (rt[1] !== 7'd5 || ra[0] !== 7'd7 || rb[0] !== 7'd8 || forward_stage !== {4'h2, 4'h4}) begin errors++; $display("FAIL dual0_fields got rt1=%0d ra0=%0d rb0=%0d fs=%h want 5 7 8 24", rt[1], ra[0], rb[0], forward_stage); end
  endtask

  task automatic test_hazard_single;
    tick();
    checks++; if (program_counter !== 6'd2 || dual_issued !== 1'b0) begin errors++; $display("FAIL haz2_pc got %0d/%b want 2/0", program_counter, dual_issued); end
    checks++; if (opcode !== {E2, ONOP} || write_back !== 2'b10) begin errors++; $display("FAIL haz2_lanes got %h/%b want %h/10", opcode, write_back, {E2, ONOP}); end
    tick();
    checks++; if (program_counter !== 6'd3 || dual_issued !== 1'b0) begin errors++; $display("FAIL haz3_pc got %0d/%b want 3/0", program_counter, dual_issued); end
    checks++; if (opcode !== {ENOP, O3} || write_back !== 2'b01 || ra[0] !== 7'd9) begin errors++; $display("FAIL haz3_lanes got %h/%b want %h/01", opcode, write_back, {ENOP, O3}); end
  endtask

  task automatic test_same_pipe;
    tick();
    checks++; if (program_counter !== 6'd4 || opcode !== {E4, ONOP} || dual_issued !== 1'b0) begin errors++; $display("FAIL same4 got pc=%0d op=%h want 4 %h", program_counter, opcode, {E4, ONOP}); end
    tick();
    checks++; if (program_counter !== 6'd5 || opcode !== {E5, ONOP} || dual_issued !== 1'b0) begin errors++; $display("FAIL same5 got pc=%0d op=%h want 5 %h", program_counter, opcode, {E5, ONOP}); end
  endtask

  task automatic test_branch;
    bit seen;
    branch_taken = 1'b1; branch_value = 16'sh0110;
    tick();
    branch_taken = 1'b0;
    checks++; if (opcode !== {ENOP, ONOP} || write_back !== 2'b00 || dual_issued !== 1'b0) begin errors++; $display("FAIL br_nop got %h/%b want %h/00", opcode, write_back, {ENOP, ONOP}); end
    seen = 0;
    for (int i = 0; i < 4 && !seen; i++) begin
      tick();
      if (program_counter == 6'd16 && dual_issued == 1'b1) seen = 1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL br_target got pc=%0d want 16", program_counter); end
    checks++; if (opcode !== {E16, O17} || rc[0] !== 7'd24 || immediate[0] !== 18'h00123) begin errors++; $display("FAIL br_lanes got %h want %h", opcode, {E16, O17}); end
  endtask

  task automatic test_wrap;
    bit seen;
    branch_taken = 1'b1; branch_value = 16'shFC3E;
    tick();
    branch_taken = 1'b0;
    seen = 0;
    for (int i = 0; i < 4 && !seen; i++) begin
      tick();
      if (program_counter == 6'd62) seen = 1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL wrap_target got pc=%0d want 62", program_counter); end
    checks++; if (opcode !== {ENOP, O62} || dual_issued !== 1'b0) begin errors++; $display("FAIL wrap62 got %h/%b want %h/0", opcode, dual_issued, {ENOP, O62}); end
    tick();
    checks++; if (program_counter !== 6'd63 || opcode !== {ENOP, O63} || dual_issued !== 1'b0) begin errors++; $display("FAIL wrap63 got pc=%0d op=%h dual=%b want 63 %h 0", program_counter, opcode, dual_issued, {ENOP, O63}); end
    tick();
    checks++; if (program_counter !== 6'd0 || opcode !== {ADD, ROT} || dual_issued !== 1'b1) begin errors++; $display("FAIL wrap0 got pc=%0d op=%h dual=%b want 0 %h 1", program_counter, opcode, dual_issued, {ADD, ROT}); end
  endtask

  task automatic test_halt;
    stop = 1'b1; branch_taken = 1'b1; branch_value = 16'sh0110;
    tick();
    stop = 1'b0; branch_taken = 1'b0;
    checks++; if (halted !== 1'b1 || opcode !== {ENOP, ONOP} || dual_issued !== 1'b0) begin errors++; $display("FAIL halt_enter got halted=%b op=%h want 1 %h", halted, opcode, {ENOP, ONOP}); end
    checks++; if (program_counter !== 6'd0) begin errors++; $display("FAIL halt_pc got %0d want 0", program_counter); end
    start = 1'b1;
    load_word(6'd0, mk(GARB, 7'd0, 7'd0, 7'd0, 7'd0, 18'h0, 1'b0, 4'h0, 1'b0));
    start = 1'b0;
    tick(); tick(); tick();
    checks++; if (halted !== 1'b1 || opcode !== {ENOP, ONOP} || program_counter !== 6'd0) begin errors++; $display("FAIL halt_hold got halted=%b op=%h pc=%0d want 1 %h 0", halted, opcode, program_counter, {ENOP, ONOP}); end
    reset = 1'b1; tick(); reset = 1'b0;
    checks++; if (halted !== 1'b0 || opcode !== {ENOP, ONOP}) begin errors++; $display("FAIL halt_reset got halted=%b op=%h want 0 %h", halted, opcode, {ENOP, ONOP}); end
    start = 1'b1; tick(); start = 1'b0;
    tick();
    checks++; if (opcode !== {ADD, ROT} || dual_issued !== 1'b1) begin errors++; $display("FAIL halt_buf got %h/%b want %h/1", opcode, dual_issued, {ADD, ROT}); end
  endtask

  task automatic test_reset_in_flush;
    branch_taken = 1'b1; branch_value = 16'sh0110;
    load_word(6'd0, mk(GARB, 7'd0, 7'd0, 7'd0, 7'd0, 18'h0, 1'b0, 4'h0, 1'b1));
    branch_taken = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0;
    checks++; if (opcode !== {ENOP, ONOP} || halted !== 1'b0 || dual_issued !== 1'b0 || program_counter !== 6'd0) begin errors++; $display("FAIL flush_reset got op=%h pc=%0d want %h 0", opcode, program_counter, {ENOP, ONOP}); end
    tick(); tick();
    checks++; if (opcode !== {ENOP, ONOP} || dual_issued !== 1'b0) begin errors++; $display("FAIL flush_idle got %h want %h", opcode, {ENOP, ONOP}); end
    start = 1'b1; tick(); start = 1'b0;
    tick();
    checks++; if (opcode !== {ADD, ROT} || program_counter !== 6'd0 || dual_issued !== 1'b1) begin errors++; $display("FAIL run_load_ignored got %h want %h", opcode, {ADD, ROT}); end
  endtask

  initial begin
    test_reset();
    load_program();
    test_dual_issue();
    test_hazard_single();
    test_same_pipe();
    test_branch();
    test_wrap();
    test_halt();
    test_reset_in_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
